alif_param_loader_multi: RTL
============================

# alif_param_loader_multi

Parametrised serial configuration loader for the ALIF neuron array. It deserialises a framed bit stream into per-channel weights plus shared dual-leak and threshold parameters. Payload is held in shadow registers and committed to the active outputs atomically, and only after a checksum byte matches. It sits between the off-chip serial configuration pin and NUM_CH neuron channels, which keep running on the old active values during a load.

## Interface
Parameters:
- NUM_CH, 4: number of weight channels (1..16).
- W_WIDTH, 3: weight width per channel (1..8).
- RATE_WIDTH, 8: leak-rate field width (1..8).
- THR_WIDTH, 8: threshold_min width (1..8).
- CYC_WIDTH, 4: leak-cycle field width (1..8).
- DEFAULT_WA, 2: reset value of every weight.
- DEFAULT_LR1, 2; DEFAULT_LR2, 1: reset leak rates.
- DEFAULT_THR, 30: reset threshold_min.
- DEFAULT_LC1, 2; DEFAULT_LC2, 4: reset leak cycles.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: global clock-enable. When low, all state and outputs freeze.
- serial_data_in, in, 1: serial bit, MSB-first per byte.
- load_enable, in, 1: frame gate. Must stay high for the whole frame.
- weights, out, NUM_CH*W_WIDTH: flattened active weights. Channel k occupies bits [k*W_WIDTH +: W_WIDTH].
- leak_rate_1 / leak_rate_2, out, RATE_WIDTH: active leak rates.
- threshold_min, out, THR_WIDTH: active minimum threshold.
- leak_cycles_1 / leak_cycles_2, out, CYC_WIDTH: active leak cycles.
- params_ready, out, 1: high when no frame is in progress.
- cfg_commit, out, 1: one-cycle pulse when the active outputs are updated.
- load_error, out, 2: result of the last frame. 00 = ok, 01 = checksum mismatch, 10 = aborted.

## Operation
Frame format:
- Payload bytes in order: weight[0]..weight[NUM_CH-1], leak_rate_1, leak_rate_2, threshold_min, leak_cycles_1, leak_cycles_2.
- Payload length P = NUM_CH+5 bytes, followed by one checksum byte equal to the XOR of all P payload bytes.
- Each field takes the low bits of its byte. Upper bits are ignored but are still included in the checksum.

States: IDLE, LOAD, CHECK, DONE.
- IDLE: on load_enable=1, go to LOAD. This cycle samples no bit. Clear byte index, bit count and XOR accumulator; set params_ready=0 and load_error=00.
- LOAD: each cycle with load_enable=1, shift in one bit. On the 8th bit:
  - write the byte to shadow field [index];
  - XOR the byte into the accumulator;
  - increment index.
  - After byte P-1, go to CHECK.
- CHECK: shift 8 bits. On the 8th bit, compare the byte with the accumulator including the current payload.
  - Match: copy all shadow fields to the active outputs, pulse cfg_commit, set params_ready=1, go to DONE.
  - Mismatch: set load_error=01 and params_ready=1; active outputs unchanged; go to DONE.
- DONE: wait for load_enable=0, then go to IDLE. A new frame requires load_enable to be low for at least one cycle.
- Abort: load_enable=0 in LOAD or CHECK goes to IDLE with load_error=10 and params_ready=1. The shadow contents are discarded and the active outputs are unchanged.
- enable=0 freezes everything: shift register, counters, state, and outputs. No bit is sampled, and load_enable is not evaluated for abort detection.

Reset:
- Outputs take their DEFAULT_* values; every weight = DEFAULT_WA.
- params_ready=1, cfg_commit=0, load_error=00.
- State = IDLE; shadow registers, counters and accumulator cleared.
- Reset mid-frame discards the frame.

## Timing
- Frame length: 1 start cycle plus 8*(P+1) bit cycles (enabled cycles only).
- Active outputs, cfg_commit and params_ready update on the clock edge that samples the last checksum bit. They are visible the next cycle.
- cfg_commit is high for exactly one enabled cycle, then returns to 0.
- Shadow writes are never visible on the outputs before commit.
- On commit, all fields change on the same edge: no partial update is ever observable.
- Outputs are registered; there is no combinational path from an input to an output.

## Structure
- Package alif_cfg_pkg holds:
  - the state enum (IDLE/LOAD/CHECK/DONE);
  - the error codes (ERR_NONE, ERR_CSUM, ERR_ABORT);
  - FIELD_BITS=8;
  - a function returning P for a given NUM_CH.
- Sub-module alif_cfg_byte_deser: 8-bit MSB-first shifter with a 3-bit counter, a clear input, a byte_done strobe and a byte output. It is gated by enable and load_enable.
- The top level holds the FSM, byte index, XOR accumulator, shadow array and active registers.

## Test plan
Unless stated, NUM_CH=2 and other parameters are at default. The good frame is bytes 05 03 10 08 40 03 06 with checksum 5B.
- Reset: assert for 2 cycles → weights = {2,2}, lr1=2, lr2=1, thr=30, lc1=2, lc2=4, params_ready=1, load_error=00.
- Good frame (65 cycles) → after the last bit, weights = {ch1=3, ch0=5}, lr1=0x10, lr2=0x08, thr=0x40, lc1=3, lc2=6. cfg_commit is high for 1 cycle; params_ready stays 0 until that edge.
- Same frame with checksum 5A → load_error=01, outputs hold the reset defaults, no cfg_commit.
- Drop load_enable after 20 bits → load_error=10, params_ready=1 next cycle, outputs unchanged. A following good frame then commits normally.
- Drive enable=0 for 5 cycles in the middle of byte 3 → the result is identical to the uninterrupted good frame, and completion is delayed by exactly 5 cycles.
- NUM_CH=1, W_WIDTH=2, weight byte 0xFF with a valid checksum → weight = 3. Upper bits are ignored but still included in the checksum.

Source files
------------

// File: rtl/alif_cfg_pkg.sv
// Shared types and constants for the ALIF serial configuration loader.
package alif_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_CSUM  = 2'b01,
    ERR_ABORT = 2'b10
  } err_t;

  localparam int FIELD_BITS = 8;

  // Payload bytes in a frame: one per weight channel plus five shared fields.
  function automatic int payload_len(input int num_ch);
    return num_ch + 5;
  endfunction

endpackage

// File: rtl/alif_cfg_byte_deser.sv
// MSB-first serial-to-byte shifter. o_byte_done strobes during the cycle whose
// edge samples the 8th bit; o_byte is the completed byte in that same cycle.
module alif_cfg_byte_deser
  import alif_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_load_enable,
  input  logic                  i_active,
  input  logic                  i_clear,
  input  logic                  i_bit,
  output logic                  o_byte_done,
  output logic [FIELD_BITS-1:0] o_byte
);

  logic [FIELD_BITS-2:0] r_shift;
  logic [2:0]            r_cnt;
  logic                  w_shift_en;

  assign w_shift_en  = i_enable & i_load_enable & i_active;
  assign o_byte_done = w_shift_en & (r_cnt == 3'd7);
  assign o_byte      = {r_shift, i_bit};

  // Shift one bit per qualified cycle; counter wraps to 0 after each byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_enable && i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_shift_en) begin
      r_shift <= o_byte[FIELD_BITS-2:0];
      r_cnt   <= r_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/alif_param_loader_multi.sv
// Framed serial loader: payload goes to shadow registers, and all active
// outputs are replaced together only after the checksum byte matches.
//
// state | meaning
// IDLE  | no frame; start on load_enable (no bit sampled that cycle)
// LOAD  | receiving payload bytes into shadow fields
// CHECK | receiving checksum byte; commit or flag mismatch on its last bit
// DONE  | frame finished; wait for load_enable low before re-arming
module alif_param_loader_multi
  import alif_cfg_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int W_WIDTH     = 3,
  parameter int RATE_WIDTH  = 8,
  parameter int THR_WIDTH   = 8,
  parameter int CYC_WIDTH   = 4,
  parameter int DEFAULT_WA  = 2,
  parameter int DEFAULT_LR1 = 2,
  parameter int DEFAULT_LR2 = 1,
  parameter int DEFAULT_THR = 30,
  parameter int DEFAULT_LC1 = 2,
  parameter int DEFAULT_LC2 = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        serial_data_in,
  input  logic                        load_enable,
  output logic [NUM_CH*W_WIDTH-1:0]   weights,
  output logic [RATE_WIDTH-1:0]       leak_rate_1,
  output logic [RATE_WIDTH-1:0]       leak_rate_2,
  output logic [THR_WIDTH-1:0]        threshold_min,
  output logic [CYC_WIDTH-1:0]        leak_cycles_1,
  output logic [CYC_WIDTH-1:0]        leak_cycles_2,
  output logic                        params_ready,
  output logic                        cfg_commit,
  output logic [1:0]                  load_error
);

  localparam int P     = payload_len(NUM_CH);
  localparam int IDX_W = $clog2(P);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [FIELD_BITS-1:0]  r_acc;
  logic                   r_ready;
  logic                   r_commit;
  logic [1:0]             r_err;

  logic [W_WIDTH-1:0]     r_sh_w [NUM_CH];
  logic [RATE_WIDTH-1:0]  r_sh_lr1, r_sh_lr2;
  logic [THR_WIDTH-1:0]   r_sh_thr;
  logic [CYC_WIDTH-1:0]   r_sh_lc1, r_sh_lc2;

  logic [W_WIDTH-1:0]     r_act_w [NUM_CH];
  logic [RATE_WIDTH-1:0]  r_act_lr1, r_act_lr2;
  logic [THR_WIDTH-1:0]   r_act_thr;
  logic [CYC_WIDTH-1:0]   r_act_lc1, r_act_lc2;

  logic                   w_byte_done;
  logic [FIELD_BITS-1:0]  w_byte;
  logic                   w_active;
  logic                   w_load_byte;
  logic                   w_check_byte;
  logic                   w_commit;

  assign w_active     = (r_state == LOAD) || (r_state == CHECK);
  assign w_load_byte  = w_byte_done && (r_state == LOAD);
  assign w_check_byte = w_byte_done && (r_state == CHECK);
  assign w_commit     = w_check_byte && (w_byte == r_acc);

  alif_cfg_byte_deser u_deser (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (enable),
    .i_load_enable (load_enable),
    .i_active      (w_active),
    .i_clear       (r_state == IDLE),
    .i_bit         (serial_data_in),
    .o_byte_done   (w_byte_done),
    .o_byte        (w_byte)
  );

  // Frame sequencing, byte index, checksum accumulator and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_acc    <= '0;
      r_ready  <= 1'b1;
      r_commit <= 1'b0;
      r_err    <= ERR_NONE;
    end else if (enable) begin
      r_commit <= 1'b0;
      case (r_state)
        IDLE: if (load_enable) begin
          r_state <= LOAD;
          r_idx   <= '0;
          r_acc   <= '0;
          r_ready <= 1'b0;
          r_err   <= ERR_NONE;
        end
        LOAD, CHECK: if (!load_enable) begin
          r_state <= IDLE;
          r_err   <= ERR_ABORT;
          r_ready <= 1'b1;
        end else if (w_load_byte) begin
          r_acc <= r_acc ^ w_byte;
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(P - 1)) r_state <= CHECK;
        end else if (w_check_byte) begin
          r_state  <= DONE;
          r_ready  <= 1'b1;
          r_commit <= w_commit;
          if (!w_commit) r_err <= ERR_CSUM;
        end
        DONE: if (!load_enable) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Shadow fields: each completed payload byte lands in the field at r_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) r_sh_w[k] <= '0;
      r_sh_lr1 <= '0;
      r_sh_lr2 <= '0;
      r_sh_thr <= '0;
      r_sh_lc1 <= '0;
      r_sh_lc2 <= '0;
    end else if (w_load_byte) begin
      for (int k = 0; k < NUM_CH; k++)
        if (r_idx == IDX_W'(k)) r_sh_w[k] <= w_byte[W_WIDTH-1:0];
      if (r_idx == IDX_W'(NUM_CH))     r_sh_lr1 <= w_byte[RATE_WIDTH-1:0];
      if (r_idx == IDX_W'(NUM_CH + 1)) r_sh_lr2 <= w_byte[RATE_WIDTH-1:0];
      if (r_idx == IDX_W'(NUM_CH + 2)) r_sh_thr <= w_byte[THR_WIDTH-1:0];
      if (r_idx == IDX_W'(NUM_CH + 3)) r_sh_lc1 <= w_byte[CYC_WIDTH-1:0];
      if (r_idx == IDX_W'(NUM_CH + 4)) r_sh_lc2 <= w_byte[CYC_WIDTH-1:0];
    end
  end

  // Active fields: all replaced on the single edge that validates the checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) r_act_w[k] <= W_WIDTH'(DEFAULT_WA);
      r_act_lr1 <= RATE_WIDTH'(DEFAULT_LR1);
      r_act_lr2 <= RATE_WIDTH'(DEFAULT_LR2);
      r_act_thr <= THR_WIDTH'(DEFAULT_THR);
      r_act_lc1 <= CYC_WIDTH'(DEFAULT_LC1);
      r_act_lc2 <= CYC_WIDTH'(DEFAULT_LC2);
    end else if (w_commit) begin
      for (int k = 0; k < NUM_CH; k++) r_act_w[k] <= r_sh_w[k];
      r_act_lr1 <= r_sh_lr1;
      r_act_lr2 <= r_sh_lr2;
      r_act_thr <= r_sh_thr;
      r_act_lc1 <= r_sh_lc1;
      // Last payload byte was written to shadow on an earlier edge.
      r_act_lc2 <= r_sh_lc2;
    end
  end

  // Flatten per-channel weights onto the output bus.
  always_comb begin
    weights = '0;
    for (int k = 0; k < NUM_CH; k++) weights[k*W_WIDTH +: W_WIDTH] = r_act_w[k];
  end

  assign leak_rate_1   = r_act_lr1;
  assign leak_rate_2   = r_act_lr2;
  assign threshold_min = r_act_thr;
  assign leak_cycles_1 = r_act_lc1;
  assign leak_cycles_2 = r_act_lc2;
  assign params_ready  = r_ready;
  assign cfg_commit    = r_commit;
  assign load_error    = r_err;

endmodule
